// File: rtl/imem_fetch_buffer.sv
// Byte-serial instruction fetch buffer: reads up to MAX_LEN bytes from a byte-wide memory
// and presents a big-endian 80-bit window. Optional macro IMEM_LEN_TRIM_EN trims fetch length by icode.
module imem_fetch_buffer #(
  parameter int MEM_DEPTH = 256,
  parameter int MAX_LEN   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [63:0] pc,
  output logic        busy,
  output logic        instr_valid,
  output logic [79:0] instr,
  output logic [3:0]  instr_len,
  output logic        mem_error,
  output logic        instr_invalid,
  output logic        imem_rd,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_rvalid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_DEPTH);
  localparam logic [3:0]  MAX_LEN_4 = 4'(MAX_LEN);

`ifdef IMEM_LEN_TRIM_EN
  function automatic logic [3:0] decode_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
      4'h7, 4'h8:             decode_len = 4'd9;
      4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
      default:                decode_len = 4'd1;
    endcase
  endfunction
`endif

  function automatic logic icode_invalid(input logic [3:0] icode);
    icode_invalid = (icode > 4'hB);
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [63:0] pc_r;
  logic [3:0]  idx_r;
  logic [3:0]  len_r;
  logic [79:0] instr_r;
  logic        mem_error_r;
  logic        instr_invalid_r;
  logic        instr_valid_r;
  logic        busy_r;
  logic        imem_rd_r;
  logic [63:0] imem_addr_r;

  logic        issue_s;
  logic        beat_s;
  logic        issue_ok_s;
  logic [64:0] issue_addr_s;
  logic [3:0]  idx_inc_s;
  logic [3:0]  first_len_s;
  logic [3:0]  len_eff_s;

`ifdef IMEM_LEN_TRIM_EN
  assign first_len_s = decode_len(imem_rdata[7:4]);
`else
  assign first_len_s = MAX_LEN_4;
`endif

  assign idx_inc_s  = idx_r + 4'd1;
  assign len_eff_s  = (idx_r == 4'd0) ? first_len_s : len_r;
  // 65-bit compare so a pc near the top of the 64-bit space cannot wrap into range
  assign issue_ok_s = (issue_addr_s < MEM_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and issue/beat strobes
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    beat_s       = 1'b0;
    issue_addr_s = {1'b0, pc_r} + {61'd0, idx_inc_s};
    case (state_r)
      IDLE: begin
        if (req) begin
          state_next_s = ISSUE;
          issue_s      = 1'b1;
          issue_addr_s = {1'b0, pc};
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        // imem_rd_r was loaded with the range check for this address on entry
        if (imem_rd_r) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = DONE;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          beat_s = 1'b1;
          if (idx_inc_s == len_eff_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ISSUE;
            issue_s      = 1'b1;
          end
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r            <= 64'd0;
      idx_r           <= 4'd0;
      len_r           <= 4'd0;
      instr_r         <= 80'd0;
      mem_error_r     <= 1'b0;
      instr_invalid_r <= 1'b0;
      instr_valid_r   <= 1'b0;
      busy_r          <= 1'b0;
      imem_rd_r       <= 1'b0;
      imem_addr_r     <= 64'd0;
    end else begin
      instr_valid_r <= (state_r == DONE);
      busy_r        <= (state_next_s != IDLE);
      imem_rd_r     <= issue_s & issue_ok_s;
      if (issue_s) begin
        imem_addr_r <= issue_addr_s[63:0];
      end
      if ((state_r == IDLE) && req) begin
        pc_r            <= pc;
        idx_r           <= 4'd0;
        len_r           <= 4'd0;
        instr_r         <= 80'd0;
        mem_error_r     <= 1'b0;
        instr_invalid_r <= 1'b0;
      end else if ((state_r == ISSUE) && !imem_rd_r) begin
        mem_error_r <= 1'b1;
      end else if (beat_s) begin
        for (int k = 0; k < 10; k++) begin
          if (idx_r == k[3:0]) begin
            instr_r[79-8*k -: 8] <= imem_rdata;
          end
        end
        idx_r <= idx_inc_s;
        if (idx_r == 4'd0) begin
          len_r           <= first_len_s;
          instr_invalid_r <= icode_invalid(imem_rdata[7:4]);
        end
      end
    end
  end

  assign busy          = busy_r;
  assign instr_valid   = instr_valid_r;
  assign instr         = instr_r;
  assign instr_len     = idx_r;
  assign mem_error     = mem_error_r;
  assign instr_invalid = instr_invalid_r;
  assign imem_rd       = imem_rd_r;
  assign imem_addr     = imem_addr_r;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed self-checking bench for imem_fetch_buffer with a variable-latency byte memory model.
module tb_imem_fetch_buffer;

`ifdef IMEM_LEN_TRIM_EN
  localparam bit TRIM = 1'b1;
`else
  localparam bit TRIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [63:0] pc = 64'd0;
  logic        busy, instr_valid, mem_error, instr_invalid, imem_rd;
  logic [79:0] instr;
  logic [3:0]  instr_len;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_rvalid;

  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        inj_rvalid = 1'b0;
  logic [7:0]  inj_rdata = 8'd0;
  logic [7:0]  mem [0:255];
  int          mem_lat = 1;
  int          next_lat = 1;
  logic        pending = 1'b0;
  int          wait_cnt = 0;
  logic [63:0] paddr = 64'd0;
  int          rd_count = 0;
  logic        overlap_seen = 1'b0;

  int errors = 0;
  int checks = 0;

  assign imem_rvalid = mem_rvalid | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_rdata : mem_rdata;

  imem_fetch_buffer dut (
    .clk(clk), .rst(rst), .req(req), .pc(pc), .busy(busy),
    .instr_valid(instr_valid), .instr(instr), .instr_len(instr_len),
    .mem_error(mem_error), .instr_invalid(instr_invalid),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    return (a < 64'd256) ? mem[a[7:0]] : 8'hEE;
  endfunction

  // latency for the next read: 0 selects random 1..4
  always @(negedge clk) next_lat <= (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;

  // memory responder; flags any read issued while another is outstanding
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pending) begin
      if (wait_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rd_byte(paddr);
        pending    <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt - 1;
      end
    end
    if (imem_rd) begin
      rd_count <= rd_count + 1;
      if (pending) overlap_seen <= 1'b1;
      if (next_lat == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rd_byte(imem_addr);
      end else begin
        pending  <= 1'b1;
        wait_cnt <= next_lat - 1;
        paddr    <= imem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    if (!TRIM) return 10;
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction

  function automatic void ref_fetch(input logic [63:0] p, output logic [79:0] ins,
                                    output int len, output logic err, output logic inv);
    int target;
    logic [63:0] a;
    logic [7:0] b;
    ins = '0; len = 0; err = 1'b0; inv = 1'b0; target = 10;
    for (int k = 0; k < 10; k++) begin
      if (len < target && !err) begin
        a = p + 64'(k);
        if (a >= 64'd256) begin
          err = 1'b1;
        end else begin
          b = mem[a[7:0]];
          ins[79-8*k -: 8] = b;
          len++;
          if (k == 0) begin
            inv = (b[7:4] > 4'hB);
            target = ref_len(b[7:4]);
          end
        end
      end
    end
  endfunction

  // call at a negedge; returns at the negedge where instr_valid is seen
  task automatic do_fetch(input logic [63:0] p, input bit hold, output int cyc, output int nrd);
    int rd0;
    bit seen;
    rd0 = rd_count; pc = p; req = 1'b1; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold) req = 1'b0;
      if (instr_valid) seen = 1'b1;
    end
    req = 1'b0;
    nrd = rd_count - rd0;
    check("fetch_done", 80'(seen), 80'd1);
  endtask

  initial begin
    int cyc, nrd, rlen;
    logic [79:0] rins;
    logic rerr, rinv;
    logic [63:0] pcs [6];
    pcs = '{64'd0, 64'd1, 64'd44, 64'd100, 64'd250, 64'd255};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF6; mem[9] = 8'hFF;
    mem[44] = 8'h10; mem[255] = 8'h60;

    repeat (3) @(negedge clk);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_valid", 80'(instr_valid), 80'd0);
    check("rst_instr", instr, 80'd0);
    check("rst_len", 80'(instr_len), 80'd0);
    check("rst_flags", 80'({mem_error, instr_invalid, imem_rd}), 80'd0);
    check("rst_addr", 80'(imem_addr), 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // irmovq, 1-cycle memory
    do_fetch(64'd0, 1'b0, cyc, nrd);
    check_int("irmovq_lat", cyc, 22);
    check("irmovq_instr", instr, 80'h30F6_0000_0000_0000_00FF);
    check("irmovq_len", 80'(instr_len), 80'd10);
    check("irmovq_err", 80'(mem_error), 80'd0);
    check("irmovq_busy", 80'(busy), 80'd0);
    check_int("irmovq_rds", nrd, 10);
    @(negedge clk);
    check("irmovq_pulse", 80'(instr_valid), 80'd0);
    check("irmovq_hold", instr, 80'h30F6_0000_0000_0000_00FF);

    // nop
    do_fetch(64'd44, 1'b0, cyc, nrd);
    check("nop_instr", instr, 80'h1000_0000_0000_0000_0000);
    check("nop_len", 80'(instr_len), 80'(TRIM ? 4'd1 : 4'd10));
    check_int("nop_rds", nrd, TRIM ? 1 : 10);
    check_int("nop_lat", cyc, TRIM ? 4 : 22);

    // top of memory: second byte address out of range
    do_fetch(64'd255, 1'b0, cyc, nrd);
    check("top_err", 80'(mem_error), 80'd1);
    check("top_len", 80'(instr_len), 80'd1);
    check("top_instr", instr, 80'h6000_0000_0000_0000_0000);
    check_int("top_rds", nrd, 1);
    check_int("top_lat", cyc, 5);

    // pc at the very top of the 64-bit space must not wrap
    do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, cyc, nrd);
    check("wrap_err", 80'(mem_error), 80'd1);
    check("wrap_len", 80'(instr_len), 80'd0);
    check_int("wrap_rds", nrd, 0);
    check_int("wrap_lat", cyc, 3);

    // invalid icode, then a valid 2-byte instruction
    mem[0] = 8'hC0;
    do_fetch(64'd0, 1'b0, cyc, nrd);
    check("inv_flag", 80'(instr_invalid), 80'd1);
    check("inv_len", 80'(instr_len), 80'(TRIM ? 4'd1 : 4'd10));
    check("inv_byte0", 80'(instr[79:72]), 80'h0C0);
    mem[1] = 8'h20; mem[2] = 8'h76;
    do_fetch(64'd1, 1'b0, cyc, nrd);
    check("rr_inv", 80'(instr_invalid), 80'd0);
    check("rr_hi", 80'(instr[79:64]), 80'h2076);
    check("rr_lo", 80'(instr[63:0]), 80'(TRIM ? 64'd0 : 64'h0000_0000_0000_FF00));
    check("rr_len", 80'(instr_len), 80'(TRIM ? 4'd2 : 4'd10));

    // random latency, spurious rvalid in IDLE, req held while busy
    mem[100] = 8'h70; mem[101] = 8'h11; mem[102] = 8'h22; mem[103] = 8'h33; mem[104] = 8'h44;
    mem[105] = 8'h55; mem[106] = 8'h66; mem[107] = 8'h77; mem[108] = 8'h88; mem[109] = 8'h99;
    mem[250] = 8'hA0; mem[251] = 8'hF0; mem[252] = 8'h12; mem[253] = 8'h34;
    mem_lat = 0;
    for (int i = 0; i < 6; i++) begin
      inj_rvalid = 1'b1; inj_rdata = 8'hAA;
      @(negedge clk);
      inj_rvalid = 1'b0;
      check("spur_busy", 80'(busy), 80'd0);
      ref_fetch(pcs[i], rins, rlen, rerr, rinv);
      do_fetch(pcs[i], 1'b1, cyc, nrd);
      check("rnd_instr", instr, rins);
      check("rnd_len", 80'(instr_len), 80'(rlen));
      check("rnd_err", 80'(mem_error), 80'(rerr));
      check("rnd_inv", 80'(instr_invalid), 80'(rinv));
      check_int("rnd_rds", nrd, rlen);
      repeat (2) @(negedge clk);
      check("rnd_no_refetch", 80'(busy), 80'd0);
    end

    // reset during WAIT of a 10-byte fetch, late rvalid afterwards
    mem[0] = 8'h30; mem[1] = 8'hF6; mem[2] = 8'h00;
    mem_lat = 4;
    repeat (3) @(negedge clk);
    pc = 64'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 80'(busy), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_instr", instr, 80'd0);
    check("abort_len", 80'(instr_len), 80'd0);
    check("abort_flags", 80'({instr_valid, mem_error, instr_invalid, imem_rd}), 80'd0);
    check("abort_addr", 80'(imem_addr), 80'd0);
    mem_lat = 1;
    repeat (6) @(negedge clk);
    check("stale_busy", 80'(busy), 80'd0);
    check("stale_instr", instr, 80'd0);
    check("stale_len", 80'(instr_len), 80'd0);

    // rst wins over req
    rst = 1'b1; req = 1'b1; pc = 64'd0;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    check("rst_prio_busy", 80'(busy), 80'd0);
    @(negedge clk);
    check("rst_prio_idle", 80'(busy), 80'd0);

    do_fetch(64'd0, 1'b0, cyc, nrd);
    check("refetch_instr", instr, 80'h30F6_0000_0000_0000_00FF);
    check("refetch_len", 80'(instr_len), 80'd10);
    check_int("refetch_lat", cyc, 22);
    check_int("refetch_rds", nrd, 10);

    check("one_outstanding", 80'(overlap_seen), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_buffer.md
Name: imem_fetch_buffer

Overview:
- Sits directly upstream of the fetch stage.
- Reads instruction bytes from a byte-wide instruction memory over a request/valid handshake, one byte per transaction.
- Assembles the bytes into the 80-bit big-endian instruction window that fetch consumes, and reports the instruction length, memory errors and invalid icodes.
- Replaces the combinational 10-byte memory slice with a real, latency-tolerant memory interface.

Parameters:
- MEM_DEPTH, 256: instruction memory size in bytes; valid addresses are 0..MEM_DEPTH-1.
- MAX_LEN, 10: instruction window width in bytes; fixed by the Y86-64 encoding.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  start a fetch at pc; sampled only in IDLE.
- pc  in  64  start byte address; captured on an accepted req.
- busy  out  1  high in every state except IDLE.
- instr_valid  out  1  one-cycle pulse; instr, instr_len, mem_error and instr_invalid are valid in this cycle.
- instr  out  80  byte k at bits [79-8k:72-8k]; bytes not fetched read as 0.
- instr_len  out  4  number of bytes fetched: 1, 2, 9 or 10.
- mem_error  out  1  an address ≥ MEM_DEPTH was needed.
- instr_invalid  out  1  icode of byte 0 is greater than 4'hB.
- imem_rd  out  1  one-cycle read strobe.
- imem_addr  out  64  read address; equals pc+idx while imem_rd is high.
- imem_rdata  in  8  read data; meaningful only with imem_rvalid.
- imem_rvalid  in  1  read data valid; latency ≥ 1 cycle after imem_rd; at most one read outstanding.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal idx=0; instr buffer cleared.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req=1, capture pc, set idx=0, clear the buffer, go to ISSUE.
  - A req while busy is ignored and is not queued.
- ISSUE:
  - If pc+idx ≥ MEM_DEPTH (unsigned 64-bit compare, no wrap), set mem_error=1 and go to DONE without asserting imem_rd.
  - Otherwise pulse imem_rd with imem_addr=pc+idx, go to WAIT.
- WAIT:
  - Hold until imem_rvalid=1, then store imem_rdata in byte slot idx.
  - When idx=0, also latch the length from the icode in imem_rdata[7:4]:
    - 0, 1, 9 → 1 byte.
    - 2, 6, A, B → 2 bytes.
    - 7, 8 → 9 bytes.
    - 3, 4, 5 → 10 bytes.
    - C..F → 1 byte and instr_invalid=1.
  - Increment idx. If idx now equals the length, go to DONE; else go to ISSUE.
- DONE: pulse instr_valid for one cycle, go to IDLE.
- instr, instr_len, mem_error and instr_invalid hold their values until the next accepted req, which clears them.
- Latency with a 1-cycle memory is 2·len+2 cycles from the accepted req to instr_valid: 4 cycles for nop, 22 for irmovq.
- On mem_error, instr_len is the count of bytes fetched so far. Bytes already captured are kept and the rest are 0.
- imem_rvalid outside WAIT is ignored.
- rst mid-operation returns to IDLE in the next cycle, and a late imem_rvalid for the aborted read is ignored.
- rst has priority over req in the same cycle.
- Only one imem_rd is issued per byte, and never while a read is outstanding.

Optional Feature:
- Macro: IMEM_LEN_TRIM_EN.
- Defined: fetch length is decoded from the icode as above.
- Undefined:
  - Always fetch MAX_LEN bytes; instr_len is always 10.
  - The address check applies to all 10 bytes, so an instruction near the top of memory can raise mem_error.
  - instr_invalid is still decoded from byte 0.

Test Plan:
- Reset, then req with pc=0 over memory holding irmovq 30 F6 00 00 00 00 00 00 00 FF, 1-cycle memory → instr=80'h30F6_0000_0000_0000_00FF, instr_len=10, instr_valid pulse 22 cycles after req, mem_error=0.
- req with pc=44 where mem[44]=8'h10 (nop) → instr=80'h10 followed by 72 zero bits, instr_len=1, exactly one imem_rd pulse; with the macro undefined, instr_len=10 and 10 pulses.
- req with pc=255, mem[255]=8'h60 (OPq, 2 bytes), MEM_DEPTH=256 → mem_error=1, instr_len=1, byte0=8'h60, no imem_rd issued for address 256.
- mem[0]=8'hC0 → instr_invalid=1, instr_len=1; a second req with pc=1 fetching 8'h20 8'h76 → instr_invalid=0, instr[79:64]=16'h2076.
- Memory model with a random 1–4 cycle rvalid delay, spurious rvalid pulses injected in IDLE, and req held high while busy → correct instr, a single fetch per accepted req, and at most one outstanding read at all times.
- Assert rst during WAIT of a 10-byte fetch, then deliver a late rvalid → busy=0 and all outputs 0 the next cycle; the stale data is discarded; the next req fetches correctly.
